// File: rtl/fetch_unit_pkg.sv
// Shared RV32I front-end types: opcodes, the fetch-to-decode queue entry, and fetch FSM states.
package rv32i_types;

  localparam logic [6:0] op_b_br  = 7'b1100011;
  localparam logic [6:0] op_b_jal = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] out_inst;
    logic        prediction;
  } if_id_stage_reg_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC steering for one instruction: JAL target, predicted-taken branch target, else pc+4.
module fetch_npc
  import rv32i_types::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        prediction_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;

  assign b_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    pc_next_o = pc_i + 32'd4;
    if (inst_i[6:0] == op_b_jal) begin
      pc_next_o = pc_i + j_imm;
    end else if (inst_i[6:0] == op_b_br && prediction_i) begin
      pc_next_o = pc_i + b_imm;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: one outstanding imem read, builds queue entries, stalls on full, squashes on redirect.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  input  logic             full,
  output logic             enq,
  output if_id_stage_reg_t if_id_reg_out,
  input  logic             branch,
  input  logic [31:0]      branch_target,
  output logic [31:0]      predict_pc,
  input  logic             prediction,
  output fetch_state_t     state_o
);

  // Handshake: enq=1 pushes if_id_reg_out this cycle and is never raised while full=1;
  // an imem request is imem_rmask=4'hF with imem_addr held until the one-cycle imem_resp.

  fetch_state_t     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      req_q;
  if_id_stage_reg_t hold_q;

  logic [31:0]      npc;
  logic [31:0]      tgt;
  logic             is_br;
  if_id_stage_reg_t fetch_entry;
  logic             unused_tgt_lsbs;

  assign tgt             = {branch_target[31:2], 2'b00};
  assign unused_tgt_lsbs = ^branch_target[1:0];
  assign is_br           = (imem_rdata[6:0] == op_b_br);

  fetch_npc u_npc (
    .pc_i        (pc_q),
    .inst_i      (imem_rdata),
    .prediction_i(prediction),
    .pc_next_o   (npc)
  );

  always_comb begin
    fetch_entry            = '0;
    fetch_entry.pc         = pc_q;
    fetch_entry.pc_next    = npc;
    fetch_entry.out_inst   = imem_rdata;
    fetch_entry.prediction = is_br & prediction;
  end

  always_comb begin
    imem_addr     = pc_q;
    imem_rmask    = 4'h0;
    enq           = 1'b0;
    if_id_reg_out = '0;
    unique case (state_q)
      FETCH: begin
        imem_rmask = 4'hF;
        if (imem_resp && !full && !branch && !rst) begin
          enq           = 1'b1;
          if_id_reg_out = fetch_entry;
        end
      end
      HOLD: begin
        if (!full && !branch && !rst) begin
          enq           = 1'b1;
          if_id_reg_out = hold_q;
        end
      end
      DROP: begin
        imem_rmask = 4'hF;
        imem_addr  = req_q;
      end
      default: ;
    endcase
  end

  assign predict_pc = imem_addr;
  assign state_o    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (branch) begin
            pc_q <= tgt;
            // Without a response in hand the old read is still in flight and must be drained.
            if (!imem_resp) begin
              req_q   <= pc_q;
              state_q <= DROP;
            end
          end else if (imem_resp) begin
            if (!full) begin
              pc_q <= npc;
            end else begin
              hold_q  <= fetch_entry;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch) begin
            hold_q  <= '0;
            pc_q    <= tgt;
            state_q <= FETCH;
          end else if (!full) begin
            pc_q    <= hold_q.pc_next;
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (branch) begin
            pc_q <= tgt;
          end
          if (imem_resp) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-2 memory model, expected-entry scoreboard, vector table plus redirect/stall sequences.
module tb_fetch_unit;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int W = $bits(if_id_stage_reg_t);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata;
  logic             imem_resp;
  logic             full = 1'b0;
  logic             enq;
  if_id_stage_reg_t if_id_reg_out;
  logic             branch = 1'b0;
  logic [31:0]      branch_target = '0;
  logic [31:0]      predict_pc;
  logic             prediction = 1'b0;
  fetch_state_t     state_o;

  int checks = 0;
  int errors = 0;
  int enq_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  mem [logic [31:0]];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .full         (full),
    .enq          (enq),
    .if_id_reg_out(if_id_reg_out),
    .branch       (branch),
    .branch_target(branch_target),
    .predict_pc   (predict_pc),
    .prediction   (prediction),
    .state_o      (state_o)
  );

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: samples a request 1ns after the edge, answers two cycles later for one cycle.
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = '0;
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp  = 1'b0;
      imem_rdata = '0;
      if (rst) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        check32("req_addr_stable", imem_addr, mem_addr_q);
        check32("req_rmask_stable", {28'd0, imem_rmask}, 32'hF);
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem.exists(mem_addr_q) ? mem[mem_addr_q] : 32'h00000013;
          mem_busy   = 1'b0;
        end
      end else if (imem_rmask == 4'hF) begin
        mem_busy   = 1'b1;
        mem_cnt    = 2;
        mem_addr_q = imem_addr;
      end
    end
  end

  // Scoreboard monitor on the falling edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check32("reset_enq", {31'd0, enq}, 32'd0);
        check_w("reset_entry", W'(if_id_reg_out), '0);
      end else if (enq === 1'b1) begin
        enq_cnt++;
        check32("enq_while_full", {31'd0, full}, 32'd0);
        check32("unexpected_enq", {31'd0, (exp_q.size() == 0)}, 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_w("entry", W'(if_id_reg_out), e);
        end
      end else begin
        check_w("idle_entry", W'(if_id_reg_out), '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    branch        = 1'b0;
    branch_target = '0;
    full          = 1'b0;
    prediction    = 1'b0;
    mem.delete();
    cyc();
    cyc();
    rst = 1'b0;
    check32("exp_q_empty", exp_q.size(), 32'd0);
    check32("reset_addr", imem_addr, RESET_PC);
    check32("reset_rmask", {28'd0, imem_rmask}, 32'hF);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    branch        = 1'b1;
    branch_target = tgt;
    cyc();
    branch        = 1'b0;
    branch_target = '0;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (!(imem_addr == a && imem_rmask == 4'hF) && n < 30) begin
      cyc();
      n++;
    end
    check32("wait_addr", imem_addr, a);
  endtask

  task automatic wait_hold();
    int n = 0;
    while (imem_rmask != 4'h0 && n < 30) begin
      cyc();
      n++;
    end
    check32("hold_entered", {28'd0, imem_rmask}, 32'd0);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] pn, input logic ep);
    if_id_stage_reg_t e;
    mem[pc]      = inst;
    e.pc         = pc;
    e.pc_next    = pn;
    e.out_inst   = inst;
    e.prediction = ep;
    exp_q.push_back(W'(e));
  endtask

  // Waits for one enq, then checks the follow-up request and freezes further pushes with full.
  task automatic wait_enq_next(input logic [31:0] exp_next);
    int start = enq_cnt;
    int n = 0;
    while (enq_cnt == start && n < 40) begin
      cyc();
      n++;
    end
    check32("enq_count", enq_cnt - start, 32'd1);
    check32("next_addr", imem_addr, exp_next);
    check32("next_rmask", {28'd0, imem_rmask}, 32'hF);
    full = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] exp_next;
    logic        exp_pred;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int start;
    vecs[0]  = '{RESET_PC,     32'h00000013, 1'b0, 32'h1eceb004, 1'b0, 0};
    vecs[1]  = '{32'h1eceb010, 32'hfe000ee3, 1'b1, 32'h1eceb00c, 1'b1, 0};
    vecs[2]  = '{32'h1eceb010, 32'hfe000ee3, 1'b0, 32'h1eceb014, 1'b0, 0};
    vecs[3]  = '{32'h1eceb020, 32'h008000ef, 1'b1, 32'h1eceb028, 1'b0, 0};
    vecs[4]  = '{32'h1eceb020, 32'h008000ef, 1'b0, 32'h1eceb028, 1'b0, 0};
    vecs[5]  = '{32'h1eceb030, 32'h00000013, 1'b1, 32'h1eceb034, 1'b0, 0};
    vecs[6]  = '{32'h1eceb050, 32'h00001463, 1'b1, 32'h1eceb058, 1'b1, 0};
    vecs[7]  = '{32'h1eceb060, 32'hffdff06f, 1'b0, 32'h1eceb05c, 1'b0, 0};
    vecs[8]  = '{32'hfffffffc, 32'h008000ef, 1'b0, 32'h00000004, 1'b0, 0};
    vecs[9]  = '{32'h1eceb040, 32'hfe000ee3, 1'b1, 32'h1eceb03c, 1'b1, 3};
    vecs[10] = '{32'h1eceb070, 32'h00001463, 1'b0, 32'h1eceb074, 1'b0, 3};

    for (int i = 0; i < 11; i++) begin
      do_reset();
      prediction = vecs[i].pred;
      push_exp(vecs[i].pc, vecs[i].inst, vecs[i].exp_next, vecs[i].exp_pred);
      if (vecs[i].pc != RESET_PC) redirect(vecs[i].pc | 32'h3);
      if (vecs[i].hold > 0) begin
        full = 1'b1;
        wait_hold();
        for (int k = 0; k < vecs[i].hold; k++) begin
          cyc();
          check32("hold_rmask", {28'd0, imem_rmask}, 32'd0);
        end
        full = 1'b0;
      end
      wait_enq_next(vecs[i].exp_next);
    end

    // Redirect with a request in flight: the late response is dropped.
    do_reset();
    mem[32'h1eceb008] = 32'h008000ef;
    redirect(32'h1eceb008);
    wait_addr(32'h1eceb008);
    redirect(32'h1eceb100);
    check32("drop_addr_held", imem_addr, 32'h1eceb008);
    push_exp(32'h1eceb100, 32'h00000013, 32'h1eceb104, 1'b0);
    wait_enq_next(32'h1eceb104);

    // Back-to-back redirects while draining keep the latest target.
    do_reset();
    redirect(32'h1eceb200);
    check32("drop_addr_first", imem_addr, RESET_PC);
    redirect(32'h1eceb302);
    push_exp(32'h1eceb300, 32'h00000013, 32'h1eceb304, 1'b0);
    wait_enq_next(32'h1eceb304);

    // Redirect in the same cycle as the response.
    do_reset();
    start = 0;
    while (!imem_resp && start < 30) begin
      cyc();
      start++;
    end
    check32("resp_seen", {31'd0, imem_resp}, 32'd1);
    start = enq_cnt;
    redirect(32'h1eceb401);
    check32("same_cycle_no_enq", enq_cnt - start, 32'd0);
    check32("same_cycle_addr", imem_addr, 32'h1eceb400);
    push_exp(32'h1eceb400, 32'h00000013, 32'h1eceb404, 1'b0);
    wait_enq_next(32'h1eceb404);

    // Redirect while holding: the held entry is discarded.
    do_reset();
    full = 1'b1;
    wait_hold();
    redirect(32'h1eceb503);
    full = 1'b0;
    check32("hold_redirect_addr", imem_addr, 32'h1eceb500);
    check32("hold_redirect_rmask", {28'd0, imem_rmask}, 32'hF);
    push_exp(32'h1eceb500, 32'h00000013, 32'h1eceb504, 1'b0);
    wait_enq_next(32'h1eceb504);

    cyc();
    check32("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end writer for the fetch-to-decode instruction queue. It owns the fetch PC and issues one outstanding instruction-memory read at a time. It forms if_id_stage_reg_t entries (pc, pc_next, out_inst, prediction) and pushes them into the queue with enq, respecting the queue's full flag. It steers the next PC using static JAL targets and the gshare predictor, and squashes in-flight work on a backend branch redirect.

Parameters:
RESET_PC, 32'h1eceb000, fetch address loaded on reset.

Ports:
clk  in  1  clock
rst  in  1  reset
imem_addr  out  32  read address, word aligned; held stable while a request is outstanding
imem_rmask  out  4  4'hF = read request; held until imem_resp
imem_rdata  in  32  instruction word, valid only when imem_resp=1
imem_resp  in  1  one-cycle read completion
full  in  1  queue full flag
enq  out  1  push if_id_reg_out into the queue this cycle
if_id_reg_out  out  if_id_stage_reg_t  entry to push; '0 when enq=0
branch  in  1  backend mispredict/redirect; the queue flushes in the same cycle
branch_target  in  32  redirect PC, valid when branch=1
predict_pc  out  32  PC presented to gshare (= imem_addr)
prediction  in  1  gshare taken prediction for predict_pc, combinational

Behaviour:
- Reset is synchronous and active-high (rst), clocked on clk. It sets pc=RESET_PC, state=FETCH, and clears the hold register. On the first cycle after reset, imem_rmask=4'hF and imem_addr=RESET_PC. enq=0 and if_id_reg_out='0 while in reset.
- State FETCH:
  - rmask=4'hF and addr=pc, driven every cycle.
  - On imem_resp, build the entry: pc, out_inst=imem_rdata, pc_next, prediction.
  - pc_next rules:
    - opcode 7'b1100011 with prediction=1: pc + sext(B-imm).
    - opcode 7'b1101111: pc + sext(J-imm).
    - Otherwise: pc+4.
    - All arithmetic is 32-bit and wraps.
  - The entry's prediction field is the prediction input for branches and 0 otherwise.
  - On resp with !full and !branch: enq=1 in the same cycle, pc<=pc_next, stay in FETCH. The next request is visible the following cycle, giving a 1-cycle resp-to-request turnaround.
  - On resp with full and !branch: latch the entry into the hold register and go to HOLD. rmask=0 from the next cycle.
- State HOLD:
  - rmask=0.
  - Drive the held entry; enq=1 on the first cycle where full=0.
  - In that cycle: pc<=held pc_next and go to FETCH.
  - The held entry is never modified while in HOLD.
- State DROP (redirect taken with a request outstanding):
  - rmask and addr stay at the old request.
  - On imem_resp, discard the data (enq=0) and go to FETCH.
- Redirect priority:
  - branch=1 overrides everything; enq is forced to 0 in that cycle, and pc<=branch_target.
  - FETCH with no resp this cycle: go to DROP.
  - FETCH with resp in the same cycle: discard the response and stay in FETCH. The next cycle requests branch_target.
  - HOLD: clear the hold register and go to FETCH.
  - DROP: update pc and stay in DROP. Back-to-back redirects keep the latest target.
- Reset asserted mid-request: discard any later imem_resp for the old request. The memory side is also reset, so no DROP is needed.
- Never more than one outstanding request. Never enq while full=1.
- branch_target[1:0] is treated as 0.

Decomposition:
- rv32i_types:
  - op_b_br and op_b_jal opcode constants.
  - if_id_stage_reg_t.
  - fetch_state_t enum {FETCH, HOLD, DROP}.
- One combinational sub-module, fetch_npc, computes pc_next from (pc, inst, prediction). It is reused by the decode-stage target check.

Test Plan:
- Reset, memory returns 32'h00000013 (addi) at 0x1eceb000 with 2-cycle latency, full=0 -> enq pulses with pc=0x1eceb000 and pc_next=0x1eceb004; next imem_addr=0x1eceb004.
- BEQ 32'hfe000ee3 (imm -4) at 0x1eceb010, prediction=1 -> pc_next=0x1eceb00c and the next request goes to 0x1eceb00c; with prediction=0 -> pc_next=0x1eceb014 and entry.prediction=0.
- JAL 32'h008000ef at 0x1eceb020 -> pc_next=0x1eceb028 regardless of prediction.
- full=1 when resp arrives -> enq=0 and rmask=0 for 3 held cycles; full drops -> one enq carrying the original entry, then the fetch resumes at pc_next.
- branch=1 with target 0x1eceb100 while a request to 0x1eceb008 is outstanding -> DROP; the late resp produces no enq; the next request is to 0x1eceb100.
- branch=1 in the same cycle as imem_resp -> enq=0 that cycle; the next imem_addr equals branch_target.
